debug_controller: RTL and testbench

- Byte-command sequencer between the UART byte interface and the MIPS pipeline.
- Loads program words into instruction memory and gates the pipeline clock-enable for run or single-step execution.
- On completion, streams PC plus the full register file back over UART TX.
- Sits at top level beside the pipeline; it is the only writer of instruction memory and the only source of o_pipe_en.

---
 rtl/debug_pkg.sv | 9 +
 rtl/debug_controller_if.sv | 29 ++
 rtl/debug_tx_serializer.sv | 43 ++++
 rtl/debug_controller.sv | 97 +++++++++
 tb/tb_debug_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: command bytes, FSM encodings and defaults shared by the debug controller blocks
package debug_pkg;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, DUMP_LATCH, DUMP_SEND, DUMP_WAIT} state_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_TXWAIT} ser_state_t;
endpackage

// File: rtl/debug_controller_if.sv
// debug_controller_if: UART byte, instruction-memory, pipeline-control and register-file debug signals
interface debug_controller_if #(
  parameter int IADDR = 8,
  parameter int WBITS = 32,
  parameter int RBITS = 5
);
  logic i_rx_valid;
  logic [7:0] i_rx_data;
  logic i_tx_busy;
  logic o_tx_start;
  logic [7:0] o_tx_data;
  logic o_imem_we;
  logic [IADDR-1:0] o_imem_addr;
  logic [WBITS-1:0] o_imem_wdata;
  logic o_pipe_en;
  logic o_pipe_rst;
  logic i_halt;
  logic [WBITS-1:0] i_pc;
  logic [RBITS-1:0] o_rf_addr;
  logic [WBITS-1:0] i_rf_data;
  modport master (
    input i_rx_valid, i_rx_data, i_tx_busy, i_halt, i_pc, i_rf_data,
    output o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata, o_pipe_en, o_pipe_rst, o_rf_addr
  );
  modport slave (
    output i_rx_valid, i_rx_data, i_tx_busy, i_halt, i_pc, i_rf_data,
    input o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata, o_pipe_en, o_pipe_rst, o_rf_addr
  );
endinterface

// File: rtl/debug_tx_serializer.sv
// debug_tx_serializer: sends one word LSB-first over the UART start/busy handshake and flags word done
module debug_tx_serializer import debug_pkg::*; #(
  parameter int WBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WBITS-1:0] word,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             done
);
  localparam int NB = WBITS / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  ser_state_t st, nx;
  logic [WBITS-1:0] sr;
  logic [BW-1:0] idx;
  logic last;
  assign last = idx == BW'(NB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_IDLE;
    else st <= nx;
  always_comb
    nx = st == S_IDLE ? (start ? S_SEND : S_IDLE) :
         st == S_SEND ? (tx_busy ? S_SEND : S_TXWAIT) :
         last ? S_IDLE : S_SEND;
  always_comb begin
    tx_start = st == S_SEND && !tx_busy;
    tx_data = 8'(sr >> {idx, 3'b000});
    done = st == S_TXWAIT && last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      idx <= '0;
    end else if (st == S_IDLE && start) begin
      sr <= word;
      idx <= '0;
    end else if (st == S_TXWAIT) begin
      idx <= idx + 1'b1;
    end
endmodule

// File: rtl/debug_controller.sv
// debug_controller: UART command sequencer that loads imem, gates run/step and dumps PC plus registers
module debug_controller import debug_pkg::*; #(
  parameter int IADDR = 8,
  parameter int WBITS = 32,
  parameter int RBITS = 5,
  parameter logic [WBITS-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input logic i_clk,
  input logic i_rst_n,
  debug_controller_if.master bus
);
  localparam int NB = WBITS / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  state_t state, next;
  logic [BW-1:0] bidx;
  logic [WBITS-1:0] asm_w, full_w, ser_word;
  logic [IADDR-1:0] wcnt;
  logic [RBITS-1:0] rcnt;
  logic load_done, halted, pc_sent, last_byte, rf_last, ser_start, ser_done;
  assign last_byte = state == LOAD && !load_done && bus.i_rx_valid && bidx == BW'(NB - 1);
  assign full_w = (asm_w >> 8) | (WBITS'(bus.i_rx_data) << (WBITS - 8));
  assign rf_last = pc_sent && rcnt == '1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:       if (bus.i_rx_valid)
                    next = bus.i_rx_data == CMD_LOAD ? LOAD :
                           bus.i_rx_data == CMD_RUN  ? RUN  :
                           bus.i_rx_data == CMD_STEP ? STEP : IDLE;
      LOAD:       if (load_done) next = IDLE;
      RUN:        if (halted || bus.i_halt) next = DUMP_LATCH;
      STEP:       next = DUMP_LATCH;
      DUMP_LATCH: next = DUMP_SEND;
      DUMP_SEND:  if (ser_done) next = rf_last ? DUMP_WAIT : DUMP_LATCH;
      DUMP_WAIT:  if (!bus.i_tx_busy) next = IDLE;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    bus.o_pipe_en = !halted && (state == STEP || (state == RUN && !bus.i_halt));
    bus.o_rf_addr = rcnt;
    ser_start = state == DUMP_LATCH;
    ser_word = pc_sent ? bus.i_rf_data : bus.i_pc;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bidx <= '0;
      asm_w <= '0;
      wcnt <= '0;
      rcnt <= '0;
      load_done <= 1'b0;
      halted <= 1'b0;
      pc_sent <= 1'b0;
      bus.o_imem_we <= 1'b0;
      bus.o_imem_addr <= '0;
      bus.o_imem_wdata <= '0;
      bus.o_pipe_rst <= 1'b0;
    end else begin
      bus.o_imem_we <= last_byte;
      bus.o_pipe_rst <= state == LOAD && load_done;
      load_done <= last_byte && (full_w == HALT_WORD || wcnt == '1);
      if (state == IDLE && bus.i_rx_valid && bus.i_rx_data == CMD_LOAD) begin
        wcnt <= '0;
        bidx <= '0;
      end else if (state == LOAD && bus.i_rx_valid && !load_done) begin
        asm_w <= full_w;
        bidx <= bidx == BW'(NB - 1) ? '0 : bidx + 1'b1;
      end
      if (last_byte) begin
        bus.o_imem_addr <= wcnt;
        bus.o_imem_wdata <= full_w;
        wcnt <= wcnt + 1'b1;
      end
      if (state == LOAD && load_done) halted <= 1'b0;
      else if ((state == RUN || state == STEP) && bus.i_halt) halted <= 1'b1;
      if (state == RUN || state == STEP) begin
        pc_sent <= 1'b0;
        rcnt <= '0;
      end else if (state == DUMP_SEND && ser_done) begin
        pc_sent <= 1'b1;
        if (pc_sent && !rf_last) rcnt <= rcnt + 1'b1;
      end
    end
  debug_tx_serializer #(.WBITS(WBITS)) u_ser (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .start(ser_start),
    .word(ser_word),
    .tx_busy(bus.i_tx_busy),
    .tx_start(bus.o_tx_start),
    .tx_data(bus.o_tx_data),
    .done(ser_done)
  );
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: directed table and sequence checks of load, step, run, dump handshake and reset
module tb_debug_controller;
  import debug_pkg::*;
  localparam logic [31:0] PC = 32'h0040_12A8;
  typedef struct {logic [7:0] b; logic we; logic [39:0] wr;} vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic busy = 0;
  int busy_len = 1;
  int left = 0;
  int n_launch = 0;
  int n_seen = 0;
  int n_tests = 0;
  int n_fail = 0;
  int tx_viol = 0;
  int en_cnt = 0;
  int rst_cnt = 0;
  int en2_cnt = 0;
  int rst2_cnt = 0;
  int tx2_cnt = 0;
  logic [7:0] tx_q[$];
  logic [39:0] wr_q[$];
  logic [39:0] wr2_q[$];
  vec_t lv[9];
  always #5 clk = ~clk;
  debug_controller_if bus ();
  debug_controller_if #(.IADDR(2)) bus2 ();
  debug_controller dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  debug_controller #(.IADDR(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));
  function automatic logic [31:0] rf_model(logic [4:0] r);
    return r == 0 ? 32'h0 : {8'(r) + 8'hC0, 8'(r) + 8'h80, 8'(r) + 8'h40, 8'(r)};
  endfunction
  function automatic logic [7:0] exp_byte(int k);
    logic [31:0] w;
    w = k < 4 ? PC : rf_model(5'(k / 4 - 1));
    return w[8 * (k % 4) +: 8];
  endfunction
  function automatic logic [63:0] outs();
    return {7'b0, bus.o_imem_we, bus.o_imem_addr, bus.o_imem_wdata, bus.o_pipe_en, bus.o_pipe_rst,
            bus.o_tx_start, bus.o_tx_data, bus.o_rf_addr};
  endfunction
  assign bus.i_pc = PC;
  assign bus.i_rf_data = rf_model(bus.o_rf_addr);
  assign bus.i_tx_busy = busy;
  assign bus2.i_pc = 32'h0;
  assign bus2.i_rf_data = 32'h0;
  assign bus2.i_tx_busy = 1'b0;
  assign bus2.i_halt = 1'b0;
  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      if (busy) tx_viol++;
      n_launch++;
      tx_q.push_back(bus.o_tx_data);
    end
    en_cnt += int'(bus.o_pipe_en);
    rst_cnt += int'(bus.o_pipe_rst);
    if (bus.o_imem_we) wr_q.push_back({bus.o_imem_addr, bus.o_imem_wdata});
    if (bus2.o_imem_we) wr2_q.push_back({6'b0, bus2.o_imem_addr, bus2.o_imem_wdata});
    en2_cnt += int'(bus2.o_pipe_en);
    rst2_cnt += int'(bus2.o_pipe_rst);
    tx2_cnt += int'(bus2.o_tx_start);
  end
  always @(posedge clk) begin
    #1;
    if (n_launch != n_seen) begin
      n_seen = n_launch;
      busy = 1;
      left = busy_len;
    end else if (left > 1) begin
      left--;
    end else begin
      left = 0;
      busy = 0;
    end
  end
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(bit sel, logic [7:0] b);
    @(posedge clk);
    #1;
    if (sel) begin
      bus2.i_rx_valid = 1;
      bus2.i_rx_data = b;
    end else begin
      bus.i_rx_valid = 1;
      bus.i_rx_data = b;
    end
    @(posedge clk);
    #1;
    bus.i_rx_valid = 0;
    bus2.i_rx_valid = 0;
  endtask
  task automatic send2_pair(logic [7:0] a, logic [7:0] b);
    @(posedge clk);
    #1;
    bus2.i_rx_valid = 1;
    bus2.i_rx_data = a;
    @(posedge clk);
    #1;
    bus2.i_rx_data = b;
    @(posedge clk);
    #1;
    bus2.i_rx_valid = 0;
  endtask
  task automatic wait_dump(int base, string nm);
    int k = 0;
    int errs = 0;
    while ((tx_q.size() - base < 132 || busy) && k < 8000) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check({nm, " byte count"}, 64'(tx_q.size() - base), 132);
    for (int i = 0; i < 132 && base + i < tx_q.size(); i++)
      if (tx_q[base + i] !== exp_byte(i)) errs++;
    check({nm, " byte content errors"}, 64'(errs), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int e0, t0, r0, w0;
    logic [31:0] w;
    lv[0] = '{CMD_LOAD, 1'b0, 40'h0};
    lv[1] = '{8'h00, 1'b0, 40'h0};
    lv[2] = '{8'h00, 1'b0, 40'h0};
    lv[3] = '{8'h01, 1'b0, 40'h0};
    lv[4] = '{8'h20, 1'b1, {8'h00, 32'h2001_0000}};
    lv[5] = '{8'hFF, 1'b0, 40'h0};
    lv[6] = '{8'hFF, 1'b0, 40'h0};
    lv[7] = '{8'hFF, 1'b0, 40'h0};
    lv[8] = '{8'hFF, 1'b1, {8'h01, 32'hFFFF_FFFF}};
    bus.i_rx_valid = 0;
    bus.i_rx_data = 0;
    bus.i_halt = 0;
    bus2.i_rx_valid = 0;
    bus2.i_rx_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1;
    r0 = rst_cnt;
    for (int i = 0; i < 9; i++) begin
      send(0, lv[i].b);
      @(negedge clk);
      check($sformatf("load vec%0d we", i), 64'(bus.o_imem_we), 64'(lv[i].we));
      if (lv[i].we) check($sformatf("load vec%0d addr/data", i), {bus.o_imem_addr, bus.o_imem_wdata}, lv[i].wr);
    end
    repeat (5) @(negedge clk);
    check("load pipe_rst pulses", 64'(rst_cnt - r0), 1);
    check("load write count", 64'(wr_q.size()), 2);
    e0 = en_cnt;
    t0 = tx_q.size();
    send(0, CMD_STEP);
    wait_dump(t0, "step");
    check("step enable cycles", 64'(en_cnt - e0), 1);
    if (tx_q.size() >= t0 + 5) begin
      check("step pc bytes", {tx_q[t0 + 3], tx_q[t0 + 2], tx_q[t0 + 1], tx_q[t0]}, PC);
      check("step byte4 reg0", tx_q[t0 + 4], 8'h00);
    end else check("step bytes present", 64'(tx_q.size() - t0), 132);
    busy_len = 20;
    e0 = en_cnt;
    t0 = tx_q.size();
    send(0, CMD_RUN);
    repeat (10) @(posedge clk);
    #1;
    bus.i_halt = 1;
    @(negedge clk);
    check("run enable in halt cycle", 64'(bus.o_pipe_en), 0);
    wait_dump(t0, "run");
    check("run enable cycles", 64'(en_cnt - e0), 10);
    check("handshake start while busy", 64'(tx_viol), 0);
    busy_len = 3;
    e0 = en_cnt;
    t0 = tx_q.size();
    send(0, CMD_RUN);
    wait_dump(t0, "rerun");
    check("rerun enable cycles", 64'(en_cnt - e0), 0);
    e0 = en_cnt;
    t0 = tx_q.size();
    w0 = wr_q.size();
    r0 = rst_cnt;
    send(0, 8'h41);
    repeat (20) @(negedge clk);
    check("unknown byte tx+en", 64'(tx_q.size() - t0 + en_cnt - e0), 0);
    check("unknown byte we+rst", 64'(wr_q.size() - w0 + rst_cnt - r0), 0);
    bus.i_halt = 0;
    send(0, CMD_LOAD);
    send(0, 8'h11);
    send(0, 8'h22);
    rst_n = 0;
    #1;
    check("mid-load reset outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1;
    w0 = wr_q.size();
    send(0, CMD_LOAD);
    foreach (lv[i]) if (i > 0) send(0, i < 5 ? 8'hAA + 8'(17 * (i - 1)) : 8'hFF);
    repeat (5) @(negedge clk);
    check("reload write count", 64'(wr_q.size() - w0), 2);
    if (wr_q.size() >= w0 + 2) begin
      check("reload word0", wr_q[w0], {8'h00, 32'hDDCC_BBAA});
      check("reload word1", wr_q[w0 + 1], {8'h01, 32'hFFFF_FFFF});
    end
    r0 = rst2_cnt;
    send(1, CMD_LOAD);
    for (int i = 0; i < 4; i++) begin
      w = 32'h1234_5600 + 32'(i);
      for (int b = 0; b < 4; b++)
        if (i == 3 && b == 3) send2_pair(w[31:24], CMD_STEP);
        else send(1, w[8 * b +: 8]);
    end
    repeat (20) @(negedge clk);
    check("full write count", 64'(wr2_q.size()), 4);
    for (int i = 0; i < 4 && i < wr2_q.size(); i++)
      check($sformatf("full word%0d", i), wr2_q[i], {6'b0, 2'(i), 32'h1234_5600 + 32'(i)});
    check("full pipe_rst pulses", 64'(rst2_cnt - r0), 1);
    check("exit-cycle byte dropped", 64'(en2_cnt + tx2_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
